// File: rtl/readout_scheduler.sv
// Readback sequencer for the analog shift-register bank: walks every enabled
// channel byte by byte, sharing the bank/byte select bus with SPI (SPI wins).
module readout_scheduler #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned BYTES_PER_CH  = 7,
  parameter logic [7:0]  CMD_START     = 8'h01,
  parameter logic [7:0]  CMD_ABORT     = 8'h02
) (
  input  logic       iclk,
  input  logic       rstn,
  input  logic [7:0] instruction,
  input  logic [7:0] trigger_channel_mask,
  input  logic [7:0] spi_load_cnt_ser,
  input  logic [2:0] spi_select_reg,
  output logic [7:0] load_cnt_ser,
  output logic [2:0] select_reg,
  output logic       byte_strobe,
  output logic [2:0] ch_idx,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] BYTE_LAST   = 3'(BYTES_PER_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_LOAD, S_DONE} state_e;

  state_e     state_q;
  logic [7:0] sync1_q, sync2_q, sync3_q, cmd_last_q;
  logic [7:0] mask_q;
  logic [2:0] ch_q, byte_q;
  logic [3:0] settle_q;
  logic [7:0] load_q;
  logic [2:0] sel_q;
  logic       busy_q, done_q;

  logic cmd_acc, spi_own, strobe_cyc;

  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    lowest_bit = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_bit = 3'(i);
    end
  endfunction

  // A command counts once sync2 has matched sync3 for an edge and differs from the last accepted one.
  assign cmd_acc    = (sync2_q == sync3_q) && (sync2_q != cmd_last_q);
  assign spi_own    = (spi_load_cnt_ser != 8'd0);
  assign strobe_cyc = (state_q == S_LOAD) && (settle_q == SETTLE_LAST) && !spi_own;

  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      sync1_q    <= 8'd0;
      sync2_q    <= 8'd0;
      sync3_q    <= 8'd0;
      cmd_last_q <= 8'd0;
      mask_q     <= 8'd0;
      ch_q       <= 3'd0;
      byte_q     <= 3'd0;
      settle_q   <= 4'd0;
      load_q     <= 8'd0;
      sel_q      <= 3'b111;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      sync1_q <= instruction;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      done_q  <= 1'b0;
      if (cmd_acc) cmd_last_q <= sync2_q;

      if (cmd_acc && (sync2_q == CMD_ABORT) && (state_q != S_IDLE)) begin
        state_q  <= S_IDLE;
        ch_q     <= 3'd0;
        byte_q   <= 3'd0;
        settle_q <= 4'd0;
        load_q   <= 8'd0;
        sel_q    <= 3'b111;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (cmd_acc && (sync2_q == CMD_START)) begin
              mask_q  <= trigger_channel_mask;
              busy_q  <= 1'b1;
              state_q <= S_ARM;
            end
          end
          S_ARM: begin
            if (!spi_own) begin
              if (mask_q == 8'd0) begin
                ch_q    <= 3'd0;
                state_q <= S_DONE;
              end else begin
                ch_q     <= lowest_bit(mask_q);
                byte_q   <= 3'd0;
                settle_q <= 4'd0;
                load_q   <= 8'd1 << lowest_bit(mask_q);
                sel_q    <= 3'd0;
                state_q  <= S_LOAD;
              end
            end
          end
          S_LOAD: begin
            // SPI ownership restarts settling of the current byte once it lets go.
            if (spi_own) begin
              settle_q <= 4'd0;
            end else if (settle_q != SETTLE_LAST) begin
              settle_q <= settle_q + 4'd1;
            end else if (byte_q != BYTE_LAST) begin
              byte_q   <= byte_q + 3'd1;
              sel_q    <= byte_q + 3'd1;
              settle_q <= 4'd0;
            end else begin
              mask_q[ch_q] <= 1'b0;
              load_q       <= 8'd0;
              sel_q        <= 3'b111;
              state_q      <= S_ARM;
            end
          end
          S_DONE: begin
            if (!spi_own) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign load_cnt_ser = spi_own ? spi_load_cnt_ser : load_q;
  assign select_reg   = spi_own ? spi_select_reg : sel_q;
  assign byte_strobe  = strobe_cyc;
  assign ch_idx       = ch_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_readout_scheduler.sv
// Scoreboard bench for readout_scheduler: scans are predicted from the channel
// mask, byte count and settle time, and a monitor checks every cycle against them.
module tb_readout_scheduler;
  localparam int S = 4;
  localparam int B = 7;
  localparam logic [7:0] START = 8'h01;
  localparam logic [7:0] ABORT = 8'h02;

  logic       iclk = 1'b0;
  logic       rstn = 1'b1;
  logic [7:0] instruction = 8'd0;
  logic [7:0] trigger_channel_mask = 8'd0;
  logic [7:0] spi_load_cnt_ser = 8'd0;
  logic [2:0] spi_select_reg = 3'd0;
  logic [7:0] load_cnt_ser;
  logic [2:0] select_reg, ch_idx;
  logic       byte_strobe, busy, done;

  readout_scheduler #(
    .SETTLE_CYCLES(S), .BYTES_PER_CH(B), .CMD_START(START), .CMD_ABORT(ABORT)
  ) dut (
    .iclk(iclk), .rstn(rstn), .instruction(instruction),
    .trigger_channel_mask(trigger_channel_mask),
    .spi_load_cnt_ser(spi_load_cnt_ser), .spi_select_reg(spi_select_reg),
    .load_cnt_ser(load_cnt_ser), .select_reg(select_reg),
    .byte_strobe(byte_strobe), .ch_idx(ch_idx), .busy(busy), .done(done)
  );

  always #5 iclk = ~iclk;

  int unsigned cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    int          ch;
    int          load;
    int          sel;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned done_exp[$];
  int unsigned busy_lo = 0, busy_hi = 0;
  int          tests = 0, fails = 0, nstrobe = 0;
  bit          mon_en = 1'b0;
  bit          exp_busy;
  exp_t        got;

  task automatic chk(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, pops predictions as the DUT produces events.
  always @(negedge iclk) begin
    if (mon_en) begin
      exp_busy = (cyc >= busy_lo) && (cyc < busy_hi);
      chk("busy", busy, exp_busy);
      if (spi_load_cnt_ser != 8'd0) begin
        chk("spi_load", load_cnt_ser, spi_load_cnt_ser);
        chk("spi_sel", select_reg, spi_select_reg);
        chk("spi_no_strobe", byte_strobe, 0);
      end else if (!exp_busy) begin
        chk("idle_load", load_cnt_ser, 0);
        chk("idle_sel", select_reg, 7);
        chk("idle_ch", ch_idx, 0);
      end
      if (byte_strobe) begin
        nstrobe++;
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          got = exp_q.pop_front();
          chk("strobe_cyc", cyc, got.cyc);
          chk("strobe_ch", ch_idx, got.ch);
          chk("strobe_load", load_cnt_ser, got.load);
          chk("strobe_sel", select_reg, got.sel);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        chk("missing_strobe", 0, 1);
        void'(exp_q.pop_front());
      end
      if (done) begin
        if (done_exp.size() == 0) chk("unexpected_done", 1, 0);
        else chk("done_cyc", cyc, done_exp.pop_front());
      end else if (done_exp.size() != 0 && done_exp[0] < cyc) begin
        chk("missing_done", 0, 1);
        void'(done_exp.pop_front());
      end
    end
  end

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) begin
      @(posedge iclk);
      #1;
    end
  endtask

  task automatic write_instr(input logic [7:0] v, output int unsigned k);
    @(posedge iclk);
    #1;
    instruction = v;
    k = cyc;
  endtask

  // Predicts one scan: channels ascending, B bytes each, S settle cycles per byte;
  // an SPI window overlapping a byte restarts its settle after the window.
  task automatic run_scan(input logic [7:0] mask, input bit use_spi, input logic [7:0] spi_v,
                          input bit rewrite, input bit do_abort);
    int unsigned k, e, t, s, st, wa, wb, dn, a, n0, nexp;
    int          off;
    bit          spi_on;
    exp_t        x;
    write_instr(8'h00, k);
    wait_cyc(k + 6);
    trigger_channel_mask = mask;
    write_instr(START, k);
    e      = k + 4;
    spi_on = use_spi && (mask != 8'd0);
    off    = $urandom_range(0, S - 1);
    wa     = e + 1 + 2 * S + off;
    wb     = wa + 9;
    t      = e;
    n0     = nstrobe;
    nexp   = 0;
    for (int c = 0; c < 8; c++) begin
      if (mask[c]) begin
        s = t + 1;
        for (int b = 0; b < B; b++) begin
          st = s + S - 1;
          if (spi_on && wa <= st && wb >= s) st = wb + S;
          x.cyc = st; x.ch = c; x.load = 1 << c; x.sel = b;
          exp_q.push_back(x);
          nexp++;
          s = st + 1;
        end
        t = s;
      end
    end
    dn      = t + 2;
    busy_lo = e;
    busy_hi = dn;
    done_exp.push_back(dn);
    if (rewrite) begin
      wait_cyc(e + 3);
      instruction          = 8'h10 + 8'($urandom_range(0, 100));
      trigger_channel_mask = 8'($urandom);
    end
    if (spi_on) begin
      wait_cyc(wa);
      spi_load_cnt_ser = spi_v;
      spi_select_reg   = 3'($urandom_range(0, 7));
      wait_cyc(wa + 10);
      spi_load_cnt_ser = 8'd0;
      spi_select_reg   = 3'd0;
    end
    if (do_abort && mask != 8'd0) begin
      wait_cyc(e + 1 + 3 * S);
      instruction = ABORT;
      k = cyc;
      a = k + 4;
      while (exp_q.size() != 0 && exp_q[$].cyc >= a) begin
        void'(exp_q.pop_back());
        nexp--;
      end
      if (done_exp.size() != 0) void'(done_exp.pop_back());
      busy_hi = a;
      wait_cyc(k + 5);
      chk("abort_idle_busy", busy, 0);
      chk("abort_idle_load", load_cnt_ser, 0);
      wait_cyc(a + 10);
    end else begin
      wait_cyc(dn + 3);
    end
    chk("strobe_count", nstrobe - n0, nexp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  initial begin
    int unsigned k, e;
    logic [7:0] m;
    #1 rstn = 1'b0;
    #2;
    chk("rst_load", load_cnt_ser, 0);
    chk("rst_sel", select_reg, 7);
    chk("rst_strobe", byte_strobe, 0);
    chk("rst_ch", ch_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    wait_cyc(3);
    rstn   = 1'b1;
    mon_en = 1'b1;

    run_scan(8'h05, 1'b0, 8'h00, 1'b0, 1'b0);
    wait_cyc(cyc + 30);
    run_scan(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    m = 8'($urandom) | 8'h01;
    run_scan(m, 1'b0, 8'h00, 1'b0, 1'b1);
    run_scan(m, 1'b0, 8'h00, 1'b0, 1'b0);
    run_scan(8'h05, 1'b1, 8'h10, 1'b0, 1'b0);
    run_scan(8'h05, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run_scan(8'($urandom), 1'($urandom), 8'($urandom_range(1, 255)), 1'($urandom), 1'b0);
    end

    // Reset in the middle of a scan.
    write_instr(8'h00, k);
    wait_cyc(k + 6);
    trigger_channel_mask = 8'hFF;
    mon_en = 1'b0;
    write_instr(START, k);
    e = k + 4;
    wait_cyc(e + 1 + 2 * S);
    chk("mid_busy", busy, 1);
    chk("mid_load", load_cnt_ser, 1);
    chk("mid_sel", select_reg, 2);
    #1;
    rstn        = 1'b0;
    instruction = 8'h00;
    #1;
    chk("async_rst_load", load_cnt_ser, 0);
    chk("async_rst_sel", select_reg, 7);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ch", ch_idx, 0);
    chk("async_rst_strobe", byte_strobe, 0);
    exp_q.delete();
    done_exp.delete();
    busy_lo = 0;
    busy_hi = 0;
    wait_cyc(cyc + 2);
    rstn   = 1'b1;
    mon_en = 1'b1;
    wait_cyc(cyc + 30);

    chk("left_strobes", exp_q.size(), 0);
    chk("left_dones", done_exp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
